// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
// Parity support is compiled in with UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int   DEF_CLKS_PER_BIT = 781;
  localparam int   DATA_BITS        = 8;
  localparam logic IDLE_LEVEL       = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter.
// Pointers carry one extra wrap bit to tell full from empty.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = DATA_BITS,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with input FIFO; LSB first.
// Define UART_TX_PARITY_EN to add an even parity bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       send,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

  state_t               r_state;
  state_t               w_state_d;
  logic [TW-1:0]        r_timer;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_d;
  logic [DATA_BITS-1:0] w_head;
  logic                 r_tx;
  logic                 w_tx_d;
  logic                 w_load;
  logic                 w_bit_done;
  logic                 w_full;
  logic                 w_empty;
`ifdef UART_TX_PARITY_EN
  logic                 r_par;
`endif

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (send),
    .i_pop   (w_load),
    .i_din   (data_in),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_bit_done = (r_timer == T_LAST);
  assign ready      = !w_full;
  assign busy       = (r_state != IDLE) || !w_empty;
  assign tx         = r_tx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_d = START;
          w_load    = 1'b1;
        end
      end
      START: begin
        if (w_bit_done) w_state_d = DATA;
      end
      DATA: begin
        if (w_bit_done && r_idx == I_LAST) begin
`ifdef UART_TX_PARITY_EN
          w_state_d = PARITY;
`else
          w_state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_done) w_state_d = STOP;
      end
`endif
      STOP: begin
        if (w_bit_done) begin
          // chain straight into the next frame
          if (!w_empty) begin
            w_state_d = START;
            w_load    = 1'b1;
          end else begin
            w_state_d = IDLE;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // tx is registered from the next state so it changes with the state
  always_comb begin
    w_shift_d = r_shift;
    if (w_load)
      w_shift_d = w_head;
    else if (r_state == DATA && w_bit_done)
      w_shift_d = r_shift >> 1;
    w_tx_d = IDLE_LEVEL;
    unique case (w_state_d)
      START:   w_tx_d = ~IDLE_LEVEL;
      DATA:    w_tx_d = w_shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_d = r_par;
`endif
      default: w_tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= IDLE_LEVEL;
    end else begin
      r_shift <= w_shift_d;
      r_tx    <= w_tx_d;
      if (w_load || r_state == IDLE || w_bit_done)
        r_timer <= '0;
      else
        r_timer <= r_timer + 1'b1;
      if (w_load)
        r_idx <= '0;
      else if (r_state == DATA && w_bit_done)
        r_idx <= r_idx + 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_par <= 1'b0;
    else if (w_load) r_par <= ^w_head;
  end
`endif

endmodule
